// File: rtl/skid_pipe_reg.sv
// ---------------------------------------------------------------------------
// skid_pipe_reg
// Two-entry valid/ready pipeline register. Words accepted from the upstream
// producer land in the main register (which drives out_data directly). If the
// consumer stalls while a word is already held, one more word is parked in the
// skid register. in_ready is derived purely from registered state, so there is
// no combinational path from out_ready to in_ready.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      upstream word valid
//   in_ready   out  1      block can accept a word this cycle
//   in_data    in   WIDTH  upstream word
//   out_valid  out  1      out_data holds a valid word
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_data   out  WIDTH  downstream word (main register)
//   level      out  2      occupancy: 0, 1 or 2 words held
// ---------------------------------------------------------------------------
module skid_pipe_reg #(
   parameter int WIDTH = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       level
);

   // The state encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;

   logic w_inFire;
   logic w_outFire;

   // Handshake flags. in_ready gates in_valid, so an unknown in_valid while
   // FULL cannot reach the state update.
   assign in_ready  = (r_state != FULL);
   assign out_valid = (r_state != EMPTY);
   assign w_inFire  = in_valid & in_ready;
   assign w_outFire = out_valid & out_ready;

   assign out_data = r_main;
   assign level    = r_state;

   // Occupancy state machine and storage. in_data is only ever sampled on an
   // accepted input, and the main register is left untouched when it drains
   // so out_data holds its last word while out_valid is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_inFire) begin
                  r_main  <= in_data;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (w_inFire && w_outFire) begin
                  r_main <= in_data;
               end else if (w_inFire) begin
                  r_skid  <= in_data;
                  r_state <= FULL;
               end else if (w_outFire) begin
                  r_state <= EMPTY;
               end
            end
            FULL: begin
               if (w_outFire) begin
                  r_main  <= r_skid;
                  r_state <= BUSY;
               end
            end
            default: begin
               r_state <= EMPTY;
            end
         endcase
      end
   end

endmodule
